// File: rtl/spmv_mem_pkg.sv
// Shared constants for the SpMV PE memory-port arbiter slice.
// Tag width, default bus widths and the fixed requester index map.
// No logic; imported by spmv_rr_arbiter and spmv_mem_arbiter.
package spmv_mem_pkg;
  localparam int TAG_W  = 3;
  localparam int ADDR_W = 48;
  localparam int DATA_W = 64;

  // Requester slots; a slot's index doubles as its load tag.
  localparam int REQ_SPM_CODE  = 0;
  localparam int REQ_SPM_ARG   = 1;
  localparam int REQ_FZIP_CODE = 2;
  localparam int REQ_FZIP_ARG  = 3;
  localparam int REQ_X_LD      = 4;
  localparam int REQ_Y_ST      = 5;
endpackage

// File: rtl/spmv_rr_arbiter.sv
// Round-robin picker: one-hot grant plus index of the first eligible requester after i_ptr.
// Latency: purely combinational.
// Backpressure: none; callers gate eligibility themselves.
module spmv_rr_arbiter
  import spmv_mem_pkg::*;
#(
  parameter int N     = 6,
  parameter int IDX_W = TAG_W
) (
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  // Walk candidates ptr+1, ptr+2, ... (wrapping) and take the first eligible one.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!o_vld && ((int'(i_ptr) + k + 1) % N) == j && i_elig[j]) begin
          o_vld    = 1'b1;
          o_gnt[j] = 1'b1;
          o_idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// Shares one PE memory port among NUM_REQ requesters; loads tagged by index, responses steered by tag.
// Latency: 1 cycle request->req_mem_*, 1 cycle rsp_mem_*->rsp_push.
// Backpressure: req_stall=~grant; req_mem_stall blocks all grants; rsp_mem_stall is advisory.
// Optional: define SPMV_MEM_ARB_STATS_EN for per-requester grant/wait counters.
module spmv_mem_arbiter
  import spmv_mem_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int MAX_OUT = 16,
  parameter int ADDR_W  = spmv_mem_pkg::ADDR_W,
  parameter int DATA_W  = spmv_mem_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_ld,
  input  logic [NUM_REQ-1:0]          req_st,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_d,
  output logic [NUM_REQ-1:0]          req_stall,
  output logic [NUM_REQ-1:0]          rsp_push,
  output logic [DATA_W-1:0]           rsp_q,
  input  logic [NUM_REQ-1:0]          rsp_stall,
  output logic                        req_mem_ld,
  output logic                        req_mem_st,
  output logic [ADDR_W-1:0]           req_mem_addr,
  output logic [DATA_W-1:0]           req_mem_d_or_tag,
  input  logic                        req_mem_stall,
  input  logic                        rsp_mem_push,
  input  logic [TAG_W-1:0]            rsp_mem_tag,
  input  logic [DATA_W-1:0]           rsp_mem_q,
  output logic                        rsp_mem_stall,
  output logic                        busy,
  output logic                        err_tag
`ifdef SPMV_MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]       stat_grant_cnt,
  output logic [NUM_REQ*32-1:0]       stat_wait_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [NUM_REQ-1:0] w_pend;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_rsp_hit;
  logic [NUM_REQ-1:0] w_cred_zero;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_gnt_vld;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_d;
  logic               w_tag_ok;
  logic               w_underflow;
  logic [TAG_W-1:0]   r_ptr;
  logic [CW-1:0]      r_credit [NUM_REQ];

  // Eligibility, response tag decode and granted-request mux.
  always_comb begin
    w_pend      = '0;
    w_elig      = '0;
    w_rsp_hit   = '0;
    w_cred_zero = '0;
    w_addr      = '0;
    w_d         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pend[i]      = req_ld[i] | req_st[i];
      w_elig[i]      = w_pend[i] & (req_st[i] | (r_credit[i] < CW'(MAX_OUT))) & ~req_mem_stall & ~rst;
      w_rsp_hit[i]   = rsp_mem_push && (rsp_mem_tag == TAG_W'(i));
      w_cred_zero[i] = (r_credit[i] == '0);
      if (w_gnt[i]) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_d    = req_d[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_tag_ok    = int'(rsp_mem_tag) < NUM_REQ;
  assign w_underflow = |(w_rsp_hit & w_cred_zero);
  assign req_stall   = ~w_gnt;
  assign busy        = (~&w_cred_zero) | (|w_pend) | req_mem_ld | req_mem_st | (|rsp_push);

  spmv_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) u_rr (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx),
    .o_vld  (w_gnt_vld)
  );

  // Register the granted request onto the memory port and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_mem_ld       <= 1'b0;
      req_mem_st       <= 1'b0;
      req_mem_addr     <= '0;
      req_mem_d_or_tag <= '0;
      r_ptr            <= TAG_W'(NUM_REQ - 1);
    end else if (w_gnt_vld) begin
      req_mem_ld       <= |(w_gnt & req_ld);
      req_mem_st       <= |(w_gnt & req_st);
      req_mem_addr     <= w_addr;
      req_mem_d_or_tag <= (|(w_gnt & req_ld)) ? DATA_W'(w_gnt_idx) : w_d;
      r_ptr            <= w_gnt_idx;
    end else begin
      req_mem_ld <= 1'b0;
      req_mem_st <= 1'b0;
    end
  end

  // Outstanding-load credits: +1 on accepted load, -1 on response; a response at zero leaves it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_credit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((w_gnt[i] & req_ld[i]) && !(w_rsp_hit[i] && !w_cred_zero[i]))
          r_credit[i] <= r_credit[i] + CW'(1);
        else if (!(w_gnt[i] & req_ld[i]) && (w_rsp_hit[i] && !w_cred_zero[i]))
          r_credit[i] <= r_credit[i] - CW'(1);
      end
    end
  end

  // Response steering, sticky error flag and registered response backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_push      <= '0;
      rsp_q         <= '0;
      err_tag       <= 1'b0;
      rsp_mem_stall <= 1'b0;
    end else begin
      rsp_push      <= w_rsp_hit;
      if (rsp_mem_push && w_tag_ok) rsp_q <= rsp_mem_q;
      err_tag       <= err_tag | (rsp_mem_push & ~w_tag_ok) | w_underflow;
      rsp_mem_stall <= |rsp_stall;
    end
  end

`ifdef SPMV_MEM_ARB_STATS_EN
  logic [31:0] r_grant_cnt [NUM_REQ];
  logic [31:0] r_wait_cnt  [NUM_REQ];

  // Saturating per-requester grant and wait counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= '0;
        r_wait_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i] && r_grant_cnt[i] != '1) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        if (w_pend[i] && !w_gnt[i] && r_wait_cnt[i] != '1) r_wait_cnt[i] <= r_wait_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grant_cnt[g*32 +: 32] = r_grant_cnt[g];
    assign stat_wait_cnt[g*32 +: 32]  = r_wait_cnt[g];
  end
`endif

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed bench for spmv_mem_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_spmv_mem_arbiter;
  localparam int N  = 6;
  localparam int AW = 48;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_ld, req_st, req_stall, rsp_push, rsp_stall;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_d;
  logic [DW-1:0]   rsp_q, req_mem_d_or_tag, rsp_mem_q;
  logic            req_mem_ld, req_mem_st, req_mem_stall, rsp_mem_push, rsp_mem_stall, busy, err_tag;
  logic [AW-1:0]   req_mem_addr;
  logic [2:0]      rsp_mem_tag;
`ifdef SPMV_MEM_ARB_STATS_EN
  logic [N*32-1:0] stat_grant_cnt, stat_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spmv_mem_arbiter #(.NUM_REQ(N), .MAX_OUT(16), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_ld(req_ld), .req_st(req_st), .req_addr(req_addr), .req_d(req_d),
    .req_stall(req_stall), .rsp_push(rsp_push), .rsp_q(rsp_q), .rsp_stall(rsp_stall),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall), .busy(busy), .err_tag(err_tag)
`ifdef SPMV_MEM_ARB_STATS_EN
    , .stat_grant_cnt(stat_grant_cnt), .stat_wait_cnt(stat_wait_cnt)
`endif
  );

  typedef struct {
    logic [N-1:0] ld;
    logic [N-1:0] st;
    logic         ms;
    logic         rp;
    logic [2:0]   rtag;
    logic [63:0]  rq;
    logic [N-1:0] e_stall;
    logic         e_ld;
    logic         e_st;
    int           e_idx;
    logic [N-1:0] e_rpush;
    logic         e_err;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [63:0] exp_addr(int i);
    return 64'(i + 1) * 64'h1000;
  endfunction

  function automatic logic [63:0] exp_d(int i);
    return (i == 5) ? 64'h3FF0_0000_0000_0000 : 64'hD0 + 64'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_ld = '0; req_st = '0; req_mem_stall = 1'b0;
    rsp_mem_push = 1'b0; rsp_mem_tag = '0; rsp_mem_q = '0; rsp_stall = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int n);
    @(negedge clk);
    req_ld = tbl[n].ld; req_st = tbl[n].st; req_mem_stall = tbl[n].ms;
    rsp_mem_push = tbl[n].rp; rsp_mem_tag = tbl[n].rtag; rsp_mem_q = tbl[n].rq;
    #1 chk($sformatf("v%0d_stall", n), 64'(req_stall), 64'(tbl[n].e_stall));
    @(posedge clk); #1;
    chk($sformatf("v%0d_ld", n), 64'(req_mem_ld), 64'(tbl[n].e_ld));
    chk($sformatf("v%0d_st", n), 64'(req_mem_st), 64'(tbl[n].e_st));
    if (tbl[n].e_ld || tbl[n].e_st) begin
      chk($sformatf("v%0d_addr", n), 64'(req_mem_addr), exp_addr(tbl[n].e_idx));
      chk($sformatf("v%0d_dtag", n), req_mem_d_or_tag,
          tbl[n].e_ld ? 64'(tbl[n].e_idx) : exp_d(tbl[n].e_idx));
    end
    chk($sformatf("v%0d_rsp_push", n), 64'(rsp_push), 64'(tbl[n].e_rpush));
    if (tbl[n].e_rpush != '0) chk($sformatf("v%0d_rsp_q", n), rsp_q, tbl[n].rq);
    chk($sformatf("v%0d_err", n), 64'(err_tag), 64'(tbl[n].e_err));
  endtask

  initial begin
    int ngnt;
    int order_bad;
    int addr_bad;
    int not_ld;

    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(exp_addr(i));
      req_d[i*DW +: DW]    = exp_d(i);
    end
    idle_inputs();
    rst = 1'b1;

    //            ld     st     ms    rp    tag   q             e_stall e_ld  e_st  idx e_rpush e_err
    tbl[0]  = '{6'h01, 6'h00, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3E, 1'b1, 1'b0, 0, 6'h00, 1'b0};
    tbl[1]  = '{6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3F, 1'b0, 1'b0, 0, 6'h00, 1'b0};
    tbl[2]  = '{6'h02, 6'h20, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3D, 1'b1, 1'b0, 1, 6'h00, 1'b0};
    tbl[3]  = '{6'h00, 6'h20, 1'b0, 1'b0, 3'd0, 64'h0,        6'h1F, 1'b0, 1'b1, 5, 6'h00, 1'b0};
    tbl[4]  = '{6'h3F, 6'h00, 1'b1, 1'b0, 3'd0, 64'h0,        6'h3F, 1'b0, 1'b0, 0, 6'h00, 1'b0};
    tbl[5]  = '{6'h3F, 6'h00, 1'b1, 1'b0, 3'd0, 64'h0,        6'h3F, 1'b0, 1'b0, 0, 6'h00, 1'b0};
    tbl[6]  = '{6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3E, 1'b1, 1'b0, 0, 6'h00, 1'b0};
    tbl[7]  = '{6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3D, 1'b1, 1'b0, 1, 6'h00, 1'b0};
    tbl[8]  = '{6'h00, 6'h00, 1'b0, 1'b1, 3'd0, 64'hDEAD,     6'h3F, 1'b0, 1'b0, 0, 6'h01, 1'b0};
    tbl[9]  = '{6'h00, 6'h00, 1'b0, 1'b1, 3'd7, 64'hBAD,      6'h3F, 1'b0, 1'b0, 0, 6'h00, 1'b1};
    tbl[10] = '{6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3F, 1'b0, 1'b0, 0, 6'h00, 1'b1};
    tbl[11] = '{6'h3F, 6'h00, 1'b0, 1'b0, 3'd0, 64'h0,        6'h3B, 1'b1, 1'b0, 2, 6'h00, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_stall", 64'(req_stall), 64'h3F);
    chk("rst_mem_ld", 64'(req_mem_ld), 64'h0);
    chk("rst_mem_st", 64'(req_mem_st), 64'h0);
    chk("rst_rsp_push", 64'(rsp_push), 64'h0);
    chk("rst_rsp_mem_stall", 64'(rsp_mem_stall), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_tag), 64'h0);
    rst = 1'b0;

    // Single load from requester 0, then its response; busy must fall afterwards.
    @(negedge clk);
    req_addr[0 +: AW] = AW'(64'h100);
    req_ld = 6'h01;
    @(posedge clk); #1;
    chk("one_ld", 64'(req_mem_ld), 64'h1);
    chk("one_addr", 64'(req_mem_addr), 64'h100);
    chk("one_tag", req_mem_d_or_tag, 64'h0);
    @(negedge clk);
    req_ld = '0;
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'd0; rsp_mem_q = 64'hDEAD;
    @(posedge clk); #1;
    chk("one_rsp_push", 64'(rsp_push), 64'h01);
    chk("one_rsp_q", rsp_q, 64'hDEAD);
    @(negedge clk);
    rsp_mem_push = 1'b0;
    @(posedge clk); #1;
    chk("one_busy_fall", 64'(busy), 64'h0);
    chk("one_err", 64'(err_tag), 64'h0);
    req_addr[0 +: AW] = AW'(exp_addr(0));

    // Vector table from a fresh reset.
    do_reset();
    for (int n = 0; n < 12; n++) run_vec(n);

    // All requesters loading, no responses: strict rotation until every credit is exhausted.
    do_reset();
    @(negedge clk);
    req_ld = 6'h3F;
    ngnt = 0; order_bad = 0; addr_bad = 0; not_ld = 0;
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); #1;
      if (req_mem_ld || req_mem_st) begin
        if (!req_mem_ld) not_ld++;
        if (req_mem_d_or_tag != 64'(ngnt % N)) order_bad++;
        if (64'(req_mem_addr) != exp_addr(ngnt % N)) addr_bad++;
        ngnt++;
      end
    end
    chk("rr_grant_count", 64'(ngnt), 64'd96);
    chk("rr_order", 64'(order_bad), 64'd0);
    chk("rr_addr", 64'(addr_bad), 64'd0);
    chk("rr_only_loads", 64'(not_ld), 64'd0);
    chk("rr_all_stalled", 64'(req_stall), 64'h3F);
    chk("rr_busy", 64'(busy), 64'h1);

    // A response for tag 3 frees exactly one credit; requester 3 gets the next slot.
    @(negedge clk);
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'd3; rsp_mem_q = 64'h33;
    @(posedge clk); #1;
    chk("cred_rsp_push", 64'(rsp_push), 64'h08);
    @(negedge clk);
    rsp_mem_push = 1'b0;
    #1 chk("cred_stall_open", 64'(req_stall), 64'h37);
    @(posedge clk); #1;
    chk("cred_regrant_ld", 64'(req_mem_ld), 64'h1);
    chk("cred_regrant_tag", req_mem_d_or_tag, 64'h3);
    @(negedge clk); #1;
    chk("cred_stall_closed", 64'(req_stall), 64'h3F);

    // Asynchronous reset mid-stream takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    chk("arst_req_stall", 64'(req_stall), 64'h3F);
    chk("arst_mem_ld", 64'(req_mem_ld), 64'h0);
    chk("arst_err", 64'(err_tag), 64'h0);
    req_ld = '0;
    @(negedge clk);
    rst = 1'b0;

    // Stale tag-2 response after reset: forwarded, flagged, credit stays at zero.
    @(negedge clk);
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'd2; rsp_mem_q = 64'h55;
    @(posedge clk); #1;
    chk("stale_rsp_push", 64'(rsp_push), 64'h04);
    chk("stale_rsp_q", rsp_q, 64'h55);
    chk("stale_err", 64'(err_tag), 64'h1);
    @(negedge clk);
    rsp_mem_push = 1'b0;
    @(posedge clk); #1;
    chk("stale_busy", 64'(busy), 64'h0);
    chk("stale_err_held", 64'(err_tag), 64'h1);

    // rsp_stall -> rsp_mem_stall with one cycle of delay in both directions.
    @(negedge clk);
    rsp_stall = 6'h08;
    #1 chk("rstall_not_yet", 64'(rsp_mem_stall), 64'h0);
    @(posedge clk); #1;
    chk("rstall_set", 64'(rsp_mem_stall), 64'h1);
    @(negedge clk);
    rsp_stall = '0;
    #1 chk("rstall_hold", 64'(rsp_mem_stall), 64'h1);
    @(posedge clk); #1;
    chk("rstall_clr", 64'(rsp_mem_stall), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
Shares the single PE memory port (ld/st request, 3-bit tag, response push) between up to 8 internal requesters: code streams, argument streams, x-vector fetch and y-vector store. Each accepted load is tagged with the requester index. Returning responses are steered back to the requester by tag. Per-requester outstanding-load credits bound the number of in-flight loads. The block sits between the spmv_pe datapath and the memory-controller port.

Parameters:
NUM_REQ, 6, number of requesters; legal range 1..8 (tag is 3 bits).
MAX_OUT, 16, maximum outstanding loads per requester.
ADDR_W, 48, byte-address width.
DATA_W, 64, data width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_ld  in  NUM_REQ  per-requester load request
req_st  in  NUM_REQ  per-requester store request (ld and st never both high for the same requester)
req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i
req_d  in  NUM_REQ*DATA_W  per-requester store data
req_stall  out  NUM_REQ  requester must hold its request while this is high
rsp_push  out  NUM_REQ  one-hot response valid
rsp_q  out  DATA_W  response data, shared by all requesters
rsp_stall  in  NUM_REQ  requester response FIFO half full
req_mem_ld  out  1  load to memory
req_mem_st  out  1  store to memory
req_mem_addr  out  ADDR_W  memory address
req_mem_d_or_tag  out  DATA_W  store data, or load tag in bits [2:0] with all upper bits 0
req_mem_stall  in  1  memory port backpressure
rsp_mem_push  in  1  memory response valid
rsp_mem_tag  in  3  response tag
rsp_mem_q  in  DATA_W  response data
rsp_mem_stall  out  1  backpressure to memory; registered OR of rsp_stall
busy  out  1  high if any load is outstanding or any request is pending
err_tag  out  1  sticky error flag (tag out of range or credit underflow)

Behaviour:
- Reset values: all outputs 0, except req_stall, which is all 1s while rst is high. Credits are set to 0. The round-robin pointer is set to NUM_REQ-1.
- Handshake: a transfer occurs on the cycle where (req_ld[i] | req_st[i]) & ~req_stall[i].
- Grant eligibility: requester i is eligible if it has a request pending, and either it is a store or credit[i] < MAX_OUT.
- Grant: round-robin starting at pointer+1 and wrapping past NUM_REQ-1. At most one grant per cycle. The pointer moves to the granted index.
- Stall output: req_stall[i] = ~grant[i]. No grants are issued while req_mem_stall=1 or rst=1.
- Request latency: 1 cycle. The granted request is registered onto req_mem_*. The next cycle, req_mem_ld/st return to 0 unless there is a new grant.
- Load tagging: the tag is the requester index, zero-extended to 64 bits.
- Credits: an accepted load increments credit[i]. A response for tag i decrements it. If both happen in the same cycle, credit[i] is unchanged. Stores never consume credit.
- Response path (1-cycle latency): on rsp_mem_push, register rsp_push[tag]=1 and rsp_q=rsp_mem_q.
- Out-of-range tag (tag >= NUM_REQ): the response is dropped and err_tag is set.
- Credit underflow: a response for a tag whose credit is 0 (e.g. a stale response after reset) is still forwarded. The credit stays at 0 and err_tag is set.
- rsp_mem_stall: driven 1 cycle after any rsp_stall bit is high. Responses arriving while it is high are still accepted; the stall is advisory, per the memory port convention.
- Reset mid-operation: asynchronous; takes effect immediately. In-flight responses after reset fall under the credit-underflow rule above.
- busy: combinational OR of all credits != 0, any request pending, req_mem_ld/st, and rsp_push.
- Credit counter width is $clog2(MAX_OUT+1).

Optional Feature:
SPMV_MEM_ARB_STATS_EN
- Defined: adds per-requester 32-bit saturating counters grant_cnt (loads+stores granted) and wait_cnt (cycles with a request pending and not granted). Exposed on output stat_grant_cnt and stat_wait_cnt, each NUM_REQ*32 bits wide. Cleared by rst.
- Undefined: these ports and counters do not exist, and there is no other functional difference.

Decomposition:
- Shared package spmv_mem_pkg: TAG_W=3, ADDR_W, DATA_W, and the requester index constants REQ_SPM_CODE, REQ_SPM_ARG, REQ_FZIP_CODE, REQ_FZIP_ARG, REQ_X_LD, REQ_Y_ST.
- One sub-module: spmv_rr_arbiter, a parameterised round-robin picker with eligibility vector in and one-hot grant plus index out.

Test Plan:
- Single requester 0 load at addr 0x100 → req_mem_ld=1, addr 0x100, d_or_tag=0 one cycle later. Response tag 0, q=0xDEAD → rsp_push=6'b000001, rsp_q=0xDEAD next cycle. credit[0] returns to 0 and busy falls.
- All 6 requesters loading continuously, memory latency 1000 → grant order 0,1,2,3,4,5,0,…. Each requester stalls after 16 outstanding loads, and no requester is starved.
- req_mem_stall high for 5 cycles mid-stream → no req_mem_ld/st issued, all req_stall high, requests held intact. Resumes with the next round-robin index.
- Requester 5 store with d=0x3FF0000000000000 concurrent with requester 1 load → both issued on successive cycles. Store carries data; credit[5] stays 0.
- Response with tag 7 (NUM_REQ=6) → no rsp_push, err_tag=1 and held. Assert rst mid-stream, then a stale tag-2 response → rsp_push[2]=1, credit stays 0, err_tag set.
- rsp_stall[3]=1 → rsp_mem_stall=1 exactly one cycle later; deassertion follows one cycle later.
